v_hier_qmon: RTL

Change monitor that sits directly downstream of the hierarchy sub-block and consumes its 4-bit `qvec` output. Every clock it compares `qvec` with the previous sample. Each change is recorded as a timestamped event in a small FIFO, which drains over a valid/ready interface. Events lost to a full FIFO are counted, and a sticky overflow flag is raised.

---
 rtl/v_hier_qmon.sv | 108 ++++++++++
 1 files changed

// File: rtl/v_hier_qmon.sv
`default_nettype none
// ============================================================================
//  Module      : v_hier_qmon
//  Description : Change monitor for a 4-bit vector. Each change is queued as a
//                timestamped record in a small FIFO drained over valid/ready.
//                Records lost to a full FIFO are counted (saturating) and
//                raise a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module v_hier_qmon #(
    parameter int DEPTH = 4,
    parameter int TSW   = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [3:0]               qvec,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TSW+3:0]           ev_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     ovf,
    output logic [7:0]               drop_cnt,
    input  logic                     ovf_clr
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam int              c_pw    = c_aw + 1;
    localparam logic [c_pw-1:0] c_depth = c_pw'(DEPTH);

    logic [TSW-1:0]  r_ts;
    logic [3:0]      r_prev;
    logic [TSW+3:0]  r_mem [DEPTH];
    logic [c_pw-1:0] r_wptr;
    logic [c_pw-1:0] r_rptr;
    logic            r_ovf;
    logic [7:0]      r_drop_cnt;

    logic [c_pw-1:0] w_fill;
    logic            w_empty;
    logic            w_full;
    logic            w_chg;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Pointers carry one extra bit so full and empty differ only in the MSB.
    assign w_fill  = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_fill == c_depth);
    assign w_chg   = en && (qvec != r_prev);
    assign w_pop   = !w_empty && ev_ready;
    assign w_push  = w_chg && (!w_full || w_pop);
    assign w_drop  = w_chg && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts   <= '0;
            r_prev <= '0;
        end else if (en) begin
            r_ts   <= r_ts + TSW'(1);
            r_prev <= qvec;
        end
    end

    // Storage needs no reset: the head mux forces zeros whenever empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= {r_ts, qvec};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_pw'(1);
            end
        end
    end

    // A drop coinciding with a clear counts as the first drop after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (ovf_clr) begin
            r_ovf      <= w_drop;
            r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop) begin
            r_ovf      <= 1'b1;
            r_drop_cnt <= (r_drop_cnt != 8'hFF) ? r_drop_cnt + 8'd1 : r_drop_cnt;
        end
    end

    assign ev_valid = !w_empty;
    assign ev_data  = w_empty ? '0 : r_mem[r_rptr[c_aw-1:0]];
    assign fill     = w_fill;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
